// File: rtl/muldiv_unit_if.sv
// Execute-stage <-> multiply/divide unit bus: operands, opcode, start pulse,
// HI/LO move-to strobes, and the busy/HI/LO/state results.
interface muldiv_unit_if;
  // Handshake: 'start' is a level-sampled one-cycle launch, accepted only while busy=0
  // and way is 0-3. busy rises on the accepting edge and falls on the edge that
  // commits hi/lo. While busy=1, start/HIw/LOw are ignored (no queueing).
  logic [31:0] w1;
  logic [31:0] w2;
  logic [2:0]  way;
  logic        start;
  logic        HIw;
  logic        LOw;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        dbg_state;

  modport master (output w1, w2, way, start, HIw, LOw,
                  input  busy, hi, lo, dbg_state);
  modport slave  (input  w1, w2, way, start, HIw, LOw,
                  output busy, hi, lo, dbg_state);
endinterface

// File: rtl/muldiv_unit.sv
// HI/LO owner for mult/multu/div/divu/mthi/mtlo: the result is computed at launch,
// held in pending registers, and committed after a fixed busy latency.
module muldiv_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic          clk,
  input logic          reset,
  muldiv_unit_if.slave bus
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t        r_state, w_next_state;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_hi, r_lo, r_pend_hi, r_pend_lo;
  logic          r_pend_wr;
  logic          w_launch, w_finish, w_mtx;

  logic        w_is_div, w_is_signed, w_div_zero;
  logic [63:0] w_a64, w_b64, w_prod;
  logic        w_a_neg, w_b_neg;
  logic [31:0] w_a_mag, w_b_mag, w_b_safe, w_q_mag, w_r_mag, w_quot, w_rem;

  assign w_is_div    = bus.way[1];
  assign w_is_signed = ~bus.way[0];
  assign w_div_zero  = (bus.w2 == 32'd0);

  // Low 64 bits of a 64x64 product of properly extended operands cover both signednesses.
  assign w_a64  = w_is_signed ? {{32{bus.w1[31]}}, bus.w1} : {32'd0, bus.w1};
  assign w_b64  = w_is_signed ? {{32{bus.w2[31]}}, bus.w2} : {32'd0, bus.w2};
  assign w_prod = w_a64 * w_b64;

  // Sign-magnitude divide: truncates toward zero and gives 0x80000000/-1 = 0x80000000 rem 0.
  assign w_a_neg  = w_is_signed & bus.w1[31];
  assign w_b_neg  = w_is_signed & bus.w2[31];
  assign w_a_mag  = w_a_neg ? (32'd0 - bus.w1) : bus.w1;
  assign w_b_mag  = w_b_neg ? (32'd0 - bus.w2) : bus.w2;
  assign w_b_safe = w_div_zero ? 32'd1 : w_b_mag;
  assign w_q_mag  = w_a_mag / w_b_safe;
  assign w_r_mag  = w_a_mag % w_b_safe;
  assign w_quot   = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
  assign w_rem    = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

  always_comb begin
    w_next_state = r_state;
    w_launch     = 1'b0;
    w_finish     = 1'b0;
    w_mtx        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start && !bus.way[2]) begin
          w_launch     = 1'b1;
          w_next_state = S_RUN;
        end else if (!bus.start) begin
          w_mtx = 1'b1;
        end
      end
      S_RUN: begin
        if (r_cnt <= CW'(1)) begin
          w_finish     = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
      r_pend_wr <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_launch) begin
        r_pend_hi <= w_is_div ? w_rem  : w_prod[63:32];
        r_pend_lo <= w_is_div ? w_quot : w_prod[31:0];
        r_pend_wr <= ~(w_is_div & w_div_zero);
        r_cnt     <= w_is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      end else if (w_finish) begin
        r_cnt <= '0;
        if (r_pend_wr) begin
          r_hi <= r_pend_hi;
          r_lo <= r_pend_lo;
        end
      end else if (r_state == S_RUN) begin
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_mtx && bus.HIw) r_hi <= bus.w1;
      if (w_mtx && bus.LOw) r_lo <= bus.w1;
    end
  end

  assign bus.busy      = (r_state == S_RUN);
  assign bus.hi        = r_hi;
  assign bus.lo        = r_lo;
  assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: drivers push expected {hi,lo} and busy length,
// a negedge monitor pops and compares on every busy falling edge.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  muldiv_unit_if bus ();

  muldiv_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] exp_q[$];
  int          exp_len_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: completion is the busy 1->0 transition outside reset.
  logic        prev_busy = 1'b0;
  int          run_len   = 0;
  logic [63:0] mon_e;
  int          mon_l;
  always @(negedge clk) begin
    if (!reset) begin
      prev_busy = 1'b0;
      run_len   = 0;
    end else begin
      if (bus.busy) begin
        run_len++;
      end else if (prev_busy) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_completion: got hi/lo %h %h expected none", bus.hi, bus.lo);
        end else begin
          mon_e = exp_q.pop_front();
          mon_l = exp_len_q.pop_front();
          check("busy_len", 64'(run_len), 64'(mon_l));
          check("result_hilo", {bus.hi, bus.lo}, mon_e);
        end
        run_len = 0;
      end
      prev_busy = bus.busy;
    end
  end

  task automatic idle_inputs();
    bus.w1 = 32'd0; bus.w2 = 32'd0; bus.way = 3'd0;
    bus.start = 1'b0; bus.HIw = 1'b0; bus.LOw = 1'b0;
  endtask

  task automatic issue(input logic [2:0] way, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input logic [63:0] exp, input int len);
    @(posedge clk); #1;
    bus.way = way; bus.w1 = a; bus.w2 = b; bus.start = 1'b1;
    if (push) begin
      exp_q.push_back(exp);
      exp_len_q.push_back(len);
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic write_hilo(input logic [31:0] h, input logic [31:0] l);
    @(posedge clk); #1;
    bus.HIw = 1'b1; bus.w1 = h;
    @(posedge clk); #1;
    bus.HIw = 1'b0; bus.LOw = 1'b1; bus.w1 = l;
    @(posedge clk); #1;
    bus.LOw = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (bus.busy && k < 60);
    if (bus.busy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_idle_timeout: got busy=1 expected busy=0 within 60 cycles");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200us");
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_hilo", {bus.hi, bus.lo}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // mthi then mtlo on consecutive edges
    @(posedge clk); #1;
    bus.HIw = 1'b1; bus.w1 = 32'h12345678;
    @(posedge clk); #1;
    check("mthi", {bus.hi, bus.lo}, {32'h12345678, 32'h0});
    bus.HIw = 1'b0; bus.LOw = 1'b1; bus.w1 = 32'h9ABCDEF0;
    @(posedge clk); #1;
    check("mtlo", {bus.hi, bus.lo}, {32'h12345678, 32'h9ABCDEF0});
    bus.LOw = 1'b0;

    // asynchronous reset while idle
    @(posedge clk); #1;
    reset = 1'b0;
    #2;
    check("idle_reset_hilo", {bus.hi, bus.lo}, 64'd0);
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1;

    // mult with hold check and ignored mthi during busy
    write_hilo(32'h11111111, 32'h22222222);
    issue(3'd0, 32'hFFFFFFFF, 32'd2, 1'b1, {32'hFFFFFFFF, 32'hFFFFFFFE}, 5);
    check("busy_after_start", 64'(bus.busy), 64'd1);
    check("hold_during_busy", {bus.hi, bus.lo}, {32'h11111111, 32'h22222222});
    bus.HIw = 1'b1; bus.LOw = 1'b1; bus.w1 = 32'hDEADBEEF;
    @(posedge clk); #1;
    bus.HIw = 1'b0; bus.LOw = 1'b0;
    check("mtx_ignored_busy", {bus.hi, bus.lo}, {32'h11111111, 32'h22222222});
    wait_idle();

    issue(3'd1, 32'hFFFFFFFF, 32'd2,          1'b1, {32'h00000001, 32'hFFFFFFFE}, 5);
    wait_idle();
    issue(3'd2, 32'hFFFFFFF9, 32'd2,          1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD}, 10);
    wait_idle();
    issue(3'd3, 32'd7,        32'd2,          1'b1, {32'h00000001, 32'h00000003}, 10);
    wait_idle();
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF,   1'b1, {32'h00000000, 32'h80000000}, 10);
    wait_idle();
    issue(3'd2, 32'd7,        32'hFFFFFFFE,   1'b1, {32'h00000001, 32'hFFFFFFFD}, 10);
    wait_idle();
    issue(3'd0, 32'h00010000, 32'h00010000,   1'b1, {32'h00000001, 32'h00000000}, 5);
    wait_idle();

    // start wins over mthi/mtlo in the same cycle
    write_hilo(32'h11111111, 32'h22222222);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.way = 3'd1; bus.w1 = 32'd3; bus.w2 = 32'd5;
    bus.HIw = 1'b1; bus.LOw = 1'b1;
    exp_q.push_back({32'h0, 32'd15});
    exp_len_q.push_back(5);
    @(posedge clk); #1;
    idle_inputs();
    check("start_beats_mtx", {bus.hi, bus.lo}, {32'h11111111, 32'h22222222});
    wait_idle();

    // reserved opcode with start: nothing happens, move-to also suppressed
    @(posedge clk); #1;
    bus.start = 1'b1; bus.way = 3'd5; bus.w1 = 32'd7; bus.w2 = 32'd9; bus.HIw = 1'b1;
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check("reserved_busy", 64'(bus.busy), 64'd0);
    check("reserved_hilo", {bus.hi, bus.lo}, {32'h0, 32'd15});

    // both move-to strobes together, then divide by zero keeps hi/lo
    @(posedge clk); #1;
    bus.HIw = 1'b1; bus.LOw = 1'b1; bus.w1 = 32'hAAAA5555;
    @(posedge clk); #1;
    bus.HIw = 1'b0; bus.LOw = 1'b0;
    check("mthi_mtlo_both", {bus.hi, bus.lo}, {32'hAAAA5555, 32'hAAAA5555});
    issue(3'd3, 32'd1234, 32'd0, 1'b1, {32'hAAAA5555, 32'hAAAA5555}, 10);
    wait_idle();

    // second start while busy is dropped, not queued
    issue(3'd0, 32'd3, 32'd4, 1'b1, {32'h0, 32'd12}, 5);
    bus.start = 1'b1; bus.way = 3'd2; bus.w1 = 32'd100; bus.w2 = 32'd7;
    @(posedge clk); #1;
    idle_inputs();
    wait_idle();
    repeat (2) @(negedge clk);
    check("no_queued_start", 64'(bus.busy), 64'd0);

    // reset in the middle of a divide discards it
    issue(3'd2, 32'd100, 32'd7, 1'b0, 64'd0, 0);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_hilo", {bus.hi, bus.lo}, 64'd0);
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (15) @(negedge clk);
    check("no_late_busy", 64'(bus.busy), 64'd0);
    check("no_late_update", {bus.hi, bus.lo}, 64'd0);

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
